// File: rtl/trace_arbiter_pkg.sv
// Shared types for the trace arbiter: FSM state encoding and the per-source FIFO entry.
package trace_arbiter_pkg;

    // Widest packet word the FIFO entry can carry; narrower words are zero-extended.
    localparam int unsigned MAX_WORD_LEN = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [MAX_WORD_LEN-1:0] word;
        logic                    last;
    } fifo_entry_t;

endpackage

// File: rtl/trace_arbiter_fifo.sv
// Per-source packet buffer with overflow accounting; sources cannot be stalled, so a
// push into a full FIFO is dropped and counted instead.
module trace_arbiter_fifo
    import trace_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WORD_LEN   = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [WORD_LEN-1:0] word_i,
    input  logic                last_i,
    input  logic                pop_i,
    input  logic                clear_i,
    output logic                empty_o,
    output logic [WORD_LEN-1:0] word_o,
    output logic                last_o,
    output logic                overflow_o,
    output logic [7:0]          drop_count_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    fifo_entry_t   mem [FIFO_DEPTH];
    fifo_entry_t   head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] tail_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_pop;
    logic          accept;
    logic          drop;

    assign empty_o  = (count == '0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign do_pop   = pop_i && !empty_o;
    assign accept   = push_i && (!full || do_pop);
    assign drop     = push_i && full && !do_pop;
    assign tail_ptr = wr_ptr - 1'b1;

    // A dropped end-of-packet word still closes the packet by marking the stored tail.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[wr_ptr] <= '{word: MAX_WORD_LEN'(word_i), last: last_i};
        end else if (drop && last_i) begin
            mem[tail_ptr].last <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({accept, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else if (clear_i) begin
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_count_o != 8'hFF) drop_count_o <= drop_count_o + 1'b1;
        end
    end

    assign head   = mem[rd_ptr];
    assign word_o = head.word[WORD_LEN-1:0];
    assign last_o = head.last;

    if (WORD_LEN < MAX_WORD_LEN) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^head.word[MAX_WORD_LEN-1:WORD_LEN];
    end

endmodule

// File: rtl/trace_arbiter.sv
// Round-robin packet arbiter merging several trace packet streams into one sink; a grant
// is held for a whole packet so packets from different sources never interleave.
module trace_arbiter
    import trace_arbiter_pkg::*;
#(
    parameter  int unsigned NR_SOURCES = 2,
    parameter  int unsigned FIFO_DEPTH = 4,
    parameter  int unsigned WORD_LEN   = 32,
    localparam int unsigned SRC_W      = (NR_SOURCES > 1) ? $clog2(NR_SOURCES) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NR_SOURCES-1:0][WORD_LEN-1:0] packet_word_i,
    input  logic [NR_SOURCES-1:0]               packet_word_valid_i,
    input  logic [NR_SOURCES-1:0]               packet_last_i,
    output logic [WORD_LEN-1:0]                 packet_word_o,
    output logic                                packet_word_valid_o,
    output logic                                packet_last_o,
    output logic [SRC_W-1:0]                    source_id_o,
    input  logic                                ready_i,
    output logic [NR_SOURCES-1:0]               overflow_o,
    output logic [NR_SOURCES-1:0][7:0]          drop_count_o,
    input  logic                                clear_i,
    output arb_state_e                          state_o
);

    // Handshake: a word transfers on a rising edge where packet_word_valid_o && ready_i;
    // while valid is high and ready is low, word/last/source_id hold their values.

    logic [NR_SOURCES-1:0]               fifo_empty;
    logic [NR_SOURCES-1:0]               fifo_pop;
    logic [NR_SOURCES-1:0][WORD_LEN-1:0] head_word;
    logic [NR_SOURCES-1:0]               head_last;

    for (genvar g = 0; g < NR_SOURCES; g++) begin : g_src
        trace_arbiter_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .WORD_LEN   (WORD_LEN)
        ) u_fifo (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .push_i       (packet_word_valid_i[g]),
            .word_i       (packet_word_i[g]),
            .last_i       (packet_last_i[g]),
            .pop_i        (fifo_pop[g]),
            .clear_i      (clear_i),
            .empty_o      (fifo_empty[g]),
            .word_o       (head_word[g]),
            .last_o       (head_last[g]),
            .overflow_o   (overflow_o[g]),
            .drop_count_o (drop_count_o[g])
        );
    end

    arb_state_e       state_q, state_d;
    logic [SRC_W-1:0] grant_q, grant_d;
    logic [SRC_W-1:0] last_grant_q, last_grant_d;
    logic [SRC_W-1:0] cand;
    logic [SRC_W-1:0] pick;
    logic             found;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_W'(NR_SOURCES - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        cand  = last_grant_q;
        pick  = '0;
        found = 1'b0;
        // Search starts one past the previous grant and wraps to source 0.
        for (int i = 0; i < NR_SOURCES; i++) begin
            cand = (cand == SRC_W'(NR_SOURCES - 1)) ? '0 : cand + 1'b1;
            if (!found && !fifo_empty[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        state_d             = state_q;
        grant_d             = grant_q;
        last_grant_d        = last_grant_q;
        fifo_pop            = '0;
        packet_word_valid_o = 1'b0;
        packet_last_o       = 1'b0;
        packet_word_o       = '0;
        source_id_o         = last_grant_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_BURST;
                    grant_d = pick;
                end
            end
            ST_BURST: begin
                source_id_o         = grant_q;
                packet_word_valid_o = !fifo_empty[grant_q];
                if (packet_word_valid_o) begin
                    packet_word_o = head_word[grant_q];
                    packet_last_o = head_last[grant_q];
                end
                if (packet_word_valid_o && ready_i) begin
                    fifo_pop[grant_q] = 1'b1;
                    if (head_last[grant_q]) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: doc/trace_arbiter.md
TRACE_ARBITER -- requirements
Module: trace_arbiter

Interface
REQ-001 Parameter NR_SOURCES, default 2, number of trace_debugger packet streams sharing one sink (2..8).
REQ-002 Parameter FIFO_DEPTH, default 4, per-source buffer entries (power of two, >=2).
REQ-003 Parameter WORD_LEN, default 32, packet word width.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 packet_word_i  input  NR_SOURCES x WORD_LEN  per-source packet word.
REQ-007 packet_word_valid_i  input  NR_SOURCES  per-source word strobe; sources have no backpressure.
REQ-008 packet_last_i  input  NR_SOURCES  marks final word of a packet.
REQ-009 packet_word_o  output  WORD_LEN  arbitrated word.
REQ-010 packet_word_valid_o  output  1  output word valid.
REQ-011 packet_last_o  output  1  output word ends packet.
REQ-012 source_id_o  output  clog2(NR_SOURCES) (min 1)  index of granted source.
REQ-013 ready_i  input  1  sink accepts word when valid and ready are both high.
REQ-014 overflow_o  output  NR_SOURCES  sticky per-source overflow flag.
REQ-015 drop_count_o  output  NR_SOURCES x 8  per-source saturating dropped-word count.
REQ-016 clear_i  input  1  synchronous clear of overflow_o and drop_count_o.

Function
REQ-017 Each source SHALL have a FIFO_DEPTH FIFO of {word, last}; valid_i with FIFO not full pushes in the same cycle.
REQ-018 Push to a full FIFO SHALL drop the word, set overflow_o[i], increment drop_count_o[i] (saturate at 255).
REQ-019 If a dropped word has last=1, the last bit of the FIFO tail entry SHALL be set, so the packet terminates.
REQ-020 Push and pop on a full FIFO in the same cycle SHALL accept the push with no drop.
REQ-021 FSM states IDLE and BURST; reset state IDLE.
REQ-022 IDLE: if any FIFO non-empty, grant the first non-empty source searching round-robin from last_grant+1 (wrap at NR_SOURCES-1 to 0); go to BURST next cycle; else stay.
REQ-023 BURST: packet_word_valid_o = granted FIFO non-empty; word/last/source_id from its head; pop on valid && ready_i.
REQ-024 BURST -> IDLE SHALL occur on the cycle a word with last=1 is accepted; last_grant updated to granted index.
REQ-025 Grant SHALL never change mid-packet; other sources only buffer or drop.
REQ-026 Arbitration latency: first word of a packet valid on output no earlier than 2 cycles after push into an empty FIFO with the arbiter in IDLE.
REQ-027 Outputs in IDLE: valid=0, last=0, word=0, source_id=last_grant.
REQ-028 clear_i SHALL take priority over a simultaneous overflow event in the same cycle (counter=0, flag=0).
REQ-029 Output word/last/source_id SHALL be held stable while valid=1 and ready_i=0.

Reset
REQ-030 rst_ni low: FIFOs empty, state IDLE, last_grant=NR_SOURCES-1 (so source 0 wins first), overflow_o=0, drop_count_o=0, valid/last/word outputs 0.
REQ-031 Reset mid-packet SHALL discard all buffered words; no partial packet emitted after reset release.

Structure
REQ-032 Package trace_arbiter_pkg SHALL hold the FSM state enum and the {word, last} entry struct.
REQ-033 One sub-module trace_arbiter_fifo (one instance per source) implementing REQ-017..REQ-020; arbiter FSM in top.

Verification
REQ-034 Single source 0, 3-word packet 0xA1,0xA2,0xA3(last), ready_i=1 -> output same order, source_id=0, last only on 0xA3, returns IDLE.
REQ-035 Both sources push 2-word packets same cycle after reset -> source 0 packet fully, then source 1; no interleave.
REQ-036 ready_i=0 while source 1 pushes 6 words, FIFO_DEPTH=4 -> 2 dropped, overflow_o[1]=1, drop_count_o[1]=2; 6th word last=1 -> 4th stored entry emitted with last=1.
REQ-037 Full FIFO, same cycle pop and push -> no drop, count unchanged.
REQ-038 Drop 300 words -> drop_count saturates 255; clear_i coincident with a drop -> count 0, flag 0.
REQ-039 Assert rst_ni mid-BURST -> valid=0 immediately, next post-reset packet emitted intact.
